// File: rtl/manchester_pkg.sv
// Types and constants shared by the Manchester receive path (decoder lanes and arbiter).
package manchester_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Wide enough for frames of up to 511 bytes; the decoder uses the same width.
  localparam int BYTE_CNT_W = 9;

  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/manchester_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above ptr, wrapping.
module manchester_rr_arbiter
  import manchester_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  localparam int LANE_W    = lane_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    ptr,
  output logic [NUM_LANES-1:0] gnt_onehot,
  output logic [LANE_W-1:0]    gnt_idx,
  output logic                 gnt_valid
);

  int lane;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    lane       = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane = int'(ptr) + i;
      if (lane >= NUM_LANES) lane = lane - NUM_LANES;
      if (!gnt_valid && req[lane]) begin
        gnt_valid        = 1'b1;
        gnt_onehot[lane] = 1'b1;
        gnt_idx          = LANE_W'(lane);
      end
    end
  end

endmodule

// File: rtl/manchester_rx_arbiter.sv
// Frame-level round-robin arbiter: forwards whole FRAME_SIZE-byte frames from one decoder
// lane at a time onto a single byte-wide AXI-Stream, aborting frames that stall too long.
module manchester_rx_arbiter
  import manchester_pkg::*;
#(
  parameter  int NUM_LANES      = 4,
  parameter  int FRAME_SIZE     = 64,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int LANE_W         = lane_w(NUM_LANES)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_LANES-1:0]   lane_enable,
  input  logic [8*NUM_LANES-1:0] s_axis_tdata,
  input  logic [NUM_LANES-1:0]   s_axis_tvalid,
  output logic [NUM_LANES-1:0]   s_axis_tready,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [LANE_W-1:0]      m_axis_tid,
  output logic                   frame_abort,
  output logic [15:0]            abort_count,
  output logic                   busy
);

  localparam int TO_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(FRAME_SIZE - 1);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LANE_W-1:0]     MAX_LANE  = LANE_W'(NUM_LANES - 1);

  arb_state_e            state_q, state_d;
  logic [LANE_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LANE_W-1:0]     grant_q, grant_d;
  logic [NUM_LANES-1:0]  grant_oh_q, grant_oh_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]       timeout_q, timeout_d;
  logic [7:0]            tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [LANE_W-1:0]     tid_q, tid_d;
  logic                  abort_q, abort_d;
  logic [15:0]           abort_cnt_q, abort_cnt_d;

  logic [NUM_LANES-1:0]  arb_oh;
  logic [LANE_W-1:0]     arb_idx;
  logic                  arb_valid;
  logic                  ready_en;
  logic                  accept;
  logic [7:0]            sel_data;
  logic [LANE_W-1:0]     next_ptr;

  manchester_rr_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_rr (
    .req        (s_axis_tvalid & lane_enable),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_oh),
    .gnt_idx    (arb_idx),
    .gnt_valid  (arb_valid)
  );

  // The single output register can take a new byte whenever it is empty or draining.
  assign ready_en      = (state_q == GRANT) && (!tvalid_q || m_axis_tready);
  assign s_axis_tready = grant_oh_q & {NUM_LANES{ready_en}};
  assign accept        = |(s_axis_tvalid & s_axis_tready);
  assign next_ptr      = (grant_q == MAX_LANE) ? '0 : grant_q + LANE_W'(1);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant_oh_q[i]) sel_data = s_axis_tdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    byte_cnt_d  = byte_cnt_q;
    timeout_d   = timeout_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tid_d       = tid_q;
    abort_d     = 1'b0;
    abort_cnt_d = abort_cnt_q;

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    if (accept) begin
      tdata_d  = sel_data;
      tid_d    = grant_q;
      tvalid_d = 1'b1;
      tlast_d  = (byte_cnt_q == LAST_BYTE);
    end

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d    = GRANT;
          grant_d    = arb_idx;
          grant_oh_d = arb_oh;
          byte_cnt_d = '0;
          timeout_d  = '0;
        end
      end
      GRANT: begin
        // An accept always beats the timeout, so a frame's final byte can never be aborted.
        if (accept) begin
          timeout_d = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            rr_ptr_d   = next_ptr;
            state_d    = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
          end
        end else if (timeout_q == TO_LAST) begin
          abort_d    = 1'b1;
          byte_cnt_d = '0;
          timeout_d  = '0;
          rr_ptr_d   = next_ptr;
          state_d    = IDLE;
          if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      byte_cnt_q  <= '0;
      timeout_q   <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tid_q       <= '0;
      abort_q     <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      byte_cnt_q  <= byte_cnt_d;
      timeout_q   <= timeout_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tid_q       <= tid_d;
      abort_q     <= abort_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;
  assign frame_abort   = abort_q;
  assign abort_count   = abort_cnt_q;
  assign busy          = (state_q == GRANT);

endmodule

// File: tb/tb_manchester_rx_arbiter.sv
// Bench for manchester_rx_arbiter: per-lane byte sources, an output scoreboard, a table of
// arbitration scenarios and hand-written timeout / reset sequences.
module tb_manchester_rx_arbiter;

  localparam int NL = 4;
  localparam int FS = 4;
  localparam int TO = 8;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] tid;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][3:0] add;
    logic [2:0]      nfr;
    logic [3:0][1:0] order;
    logic            tog;
  } scen_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [NL-1:0] lane_enable;
  logic [8*NL-1:0] s_axis_tdata;
  logic [NL-1:0] s_axis_tvalid;
  logic [NL-1:0] s_axis_tready;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [1:0]    m_axis_tid;
  logic          frame_abort;
  logic [15:0]   abort_count;
  logic          busy;

  manchester_rx_arbiter #(
    .NUM_LANES      (NL),
    .FRAME_SIZE     (FS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .lane_enable   (lane_enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .frame_abort   (frame_abort),
    .abort_count   (abort_count),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  int    checks = 0;
  int    errors = 0;
  int    src_cnt[NL];
  int    src_lim[NL];
  int    exp_cnt[NL];
  logic [3:0] en_cfg;
  bit    tog;
  beat_t expq[$];
  beat_t held;
  bit    held_valid;
  scen_t tbl[4];

  function automatic logic [7:0] srcByte(input int lane, input int c);
    if (lane == 2 && c < 4) return 8'((c + 1) * 17);
    return 8'(lane * 64 + c);
  endfunction

  task automatic checkEq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic checkBeat(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got data=%02h tid=%0d last=%0b, expected data=%02h tid=%0d last=%0b",
               name, act.data, act.tid, act.last, exp.data, exp.tid, exp.last);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NL; i++) begin
      s_axis_tvalid[i]        = (src_cnt[i] < src_lim[i]);
      s_axis_tdata[8*i +: 8]  = srcByte(i, src_cnt[i]);
    end
    lane_enable = en_cfg;
  endtask

  task automatic pushBeats(input int lane, input int n, input bit frame_end);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = srcByte(lane, exp_cnt[lane]);
      b.tid  = 2'(lane);
      b.last = frame_end && (k == n - 1);
      expq.push_back(b);
      exp_cnt[lane]++;
    end
  endtask

  // Sampled mid-cycle: a beat visible with ready high here transfers at the next rising edge.
  task automatic checkOutput();
    beat_t act;
    beat_t exp;
    act = {m_axis_tdata, m_axis_tid, m_axis_tlast};
    if (m_axis_tvalid !== 1'b1) begin
      held_valid = 1'b0;
      return;
    end
    if (held_valid) checkBeat("stall_hold", act, held);
    if (m_axis_tready) begin
      held_valid = 1'b0;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got data=%02h tid=%0d last=%0b, expected no beat",
                 act.data, act.tid, act.last);
      end else begin
        exp = expq.pop_front();
        checkBeat("beat", act, exp);
      end
    end else begin
      held       = act;
      held_valid = 1'b1;
    end
  endtask

  task automatic step();
    logic [NL-1:0] hs;
    @(negedge aclk);
    hs = s_axis_tvalid & s_axis_tready;
    checkOutput();
    @(posedge aclk);
    #1;
    for (int i = 0; i < NL; i++) if (hs[i] === 1'b1) src_cnt[i]++;
    m_axis_tready = tog ? ~m_axis_tready : 1'b1;
    applyStimulus();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(expq.size() == 0 && m_axis_tvalid == 1'b0 && busy == 1'b0)) begin
      step();
      n++;
    end
    checkEq("drain_left", expq.size(), 0);
    tog           = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic checkResetState();
    checkEq("rst_tvalid", int'(m_axis_tvalid), 0);
    checkEq("rst_tlast", int'(m_axis_tlast), 0);
    checkEq("rst_tdata", int'(m_axis_tdata), 0);
    checkEq("rst_tid", int'(m_axis_tid), 0);
    checkEq("rst_s_tready", int'(s_axis_tready), 0);
    checkEq("rst_frame_abort", int'(frame_abort), 0);
    checkEq("rst_abort_count", int'(abort_count), 0);
    checkEq("rst_busy", int'(busy), 0);
  endtask

  // One sampled reset edge, then sources restart from byte 0 on every lane.
  task automatic resetDut();
    aresetn = 1'b0;
    step();
    for (int i = 0; i < NL; i++) begin
      src_cnt[i] = 0;
      src_lim[i] = 0;
      exp_cnt[i] = 0;
    end
    checkResetState();
    aresetn       = 1'b1;
    en_cfg        = 4'b1111;
    tog           = 1'b0;
    m_axis_tready = 1'b1;
    applyStimulus();
  endtask

  initial begin
    // add/order are packed lane3..lane0 and frame3..frame0
    tbl[0].en = 4'b1111; tbl[0].add = {4'd4, 4'd0, 4'd4, 4'd8}; tbl[0].nfr = 3'd4;
    tbl[0].order = {2'd0, 2'd3, 2'd1, 2'd0}; tbl[0].tog = 1'b0;
    tbl[1].en = 4'b1111; tbl[1].add = {4'd0, 4'd4, 4'd0, 4'd0}; tbl[1].nfr = 3'd1;
    tbl[1].order = {2'd0, 2'd0, 2'd0, 2'd2}; tbl[1].tog = 1'b1;
    tbl[2].en = 4'b0101; tbl[2].add = {4'd4, 4'd8, 4'd4, 4'd8}; tbl[2].nfr = 3'd4;
    tbl[2].order = {2'd2, 2'd0, 2'd2, 2'd0}; tbl[2].tog = 1'b1;
    tbl[3].en = 4'b1111; tbl[3].add = {4'd0, 4'd0, 4'd0, 4'd0}; tbl[3].nfr = 3'd2;
    tbl[3].order = {2'd0, 2'd0, 2'd1, 2'd3}; tbl[3].tog = 1'b0;

    for (int i = 0; i < NL; i++) begin
      src_cnt[i] = 0;
      src_lim[i] = 0;
      exp_cnt[i] = 0;
    end
    held_valid    = 1'b0;
    en_cfg        = 4'b1111;
    tog           = 1'b0;
    aresetn       = 1'b0;
    m_axis_tready = 1'b1;
    applyStimulus();
    resetDut();

    // Single lane-2 frame: latency, tid and tlast placement
    src_lim[2] = 4;
    pushBeats(2, 4, 1'b1);
    applyStimulus();
    step();
    checkEq("t1_busy_on_grant", int'(busy), 1);
    checkEq("t1_no_early_valid", int'(m_axis_tvalid), 0);
    step();
    checkEq("t1_first_valid", int'(m_axis_tvalid), 1);
    checkEq("t1_first_data", int'(m_axis_tdata), 'h11);
    checkEq("t1_first_tid", int'(m_axis_tid), 2);
    checkEq("t1_first_tlast", int'(m_axis_tlast), 0);
    steps(3);
    checkEq("t1_last_tlast", int'(m_axis_tlast), 1);
    checkEq("t1_busy_after", int'(busy), 0);
    drain(50);

    // Arbitration scenarios from a freshly reset pointer
    resetDut();
    for (int s = 0; s < 4; s++) begin
      en_cfg = tbl[s].en;
      tog    = tbl[s].tog;
      for (int i = 0; i < NL; i++) src_lim[i] += int'(tbl[s].add[i]);
      for (int f = 0; f < int'(tbl[s].nfr); f++) pushBeats(int'(tbl[s].order[f]), FS, 1'b1);
      applyStimulus();
      drain(300);
    end

    // Dropping the enable of the granted lane mid-frame must not cut the frame short
    en_cfg     = 4'b0001;
    src_lim[0] += 4;
    pushBeats(0, 4, 1'b1);
    applyStimulus();
    steps(3);
    en_cfg = 4'b0000;
    applyStimulus();
    drain(50);
    checkEq("t5_no_regrant", int'(busy), 0);

    // Lane 1 stalls after 2 of 4 bytes; lane 2 waits behind it
    resetDut();
    src_lim[1] = 2;
    src_lim[2] = 4;
    pushBeats(1, 2, 1'b0);
    pushBeats(2, 4, 1'b1);
    applyStimulus();
    step();
    checkEq("t4_grant_lane1", int'(busy), 1);
    steps(2);
    steps(7);
    checkEq("t4_no_early_abort", int'(frame_abort), 0);
    checkEq("t4_still_busy", int'(busy), 1);
    step();
    checkEq("t4_abort_pulse", int'(frame_abort), 1);
    checkEq("t4_abort_count", int'(abort_count), 1);
    checkEq("t4_idle_on_abort", int'(busy), 0);
    step();
    checkEq("t4_abort_one_cycle", int'(frame_abort), 0);
    checkEq("t4_regrant", int'(busy), 1);
    drain(50);
    checkEq("t4_abort_count_held", int'(abort_count), 1);

    // Reset in the middle of a lane-3 frame, then arbitration restarts at lane 0
    src_lim[3] = 4;
    pushBeats(3, 2, 1'b0);
    applyStimulus();
    steps(3);
    resetDut();
    src_lim[0] = 4;
    src_lim[3] = 4;
    pushBeats(0, 4, 1'b1);
    pushBeats(3, 4, 1'b1);
    applyStimulus();
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
